// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-cycle CPU.
// Used by imm_pc and imm_ext.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [5:0]      opcode_t;

    localparam opcode_t OP_ANDI = 6'h0C;
    localparam opcode_t OP_ORI  = 6'h0D;
    localparam opcode_t OP_XORI = 6'h0E;

    function automatic logic is_logic_imm(input opcode_t op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/imm_ext.sv
// Immediate extender: datapath imm plus sign-extended copy for branches.
// Optional macro IMM_ZEXT_EN: zero-extend for andi/ori/xori.
module imm_ext
    import cpu_pkg::*;
(
    input  word_t instr_i,
    output word_t imm_o,
    output word_t imm_sext_o
);

    word_t sext;
    word_t zext;

    assign sext       = {{16{instr_i[15]}}, instr_i[15:0]};
    assign zext       = {16'h0000, instr_i[15:0]};
    assign imm_sext_o = sext;

`ifdef IMM_ZEXT_EN
    opcode_t op;
    assign op    = instr_i[31:26];
    assign imm_o = is_logic_imm(op) ? zext : sext;
`else
    logic unused_hi;
    assign unused_hi = ^{instr_i[31:16], zext[15:0]};
    assign imm_o     = sext;
`endif

endmodule

// File: rtl/imm_pc.sv
// PC register and next-PC selection (sequential / branch / jump).
// Optional macro IMM_ZEXT_EN selects zero-extended logical immediates.
module imm_pc
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  reset,
    input  word_t Instr,
    input  logic  Jump,
    input  logic  Bzero,
    output word_t imm,
    output word_t PC
);

    word_t pc_q;
    word_t pc_d;
    word_t pc4;
    word_t br_tgt;
    word_t j_tgt;
    word_t imm_sext;

    imm_ext u_imm_ext (
        .instr_i    (Instr),
        .imm_o      (imm),
        .imm_sext_o (imm_sext)
    );

    assign pc4    = pc_q + word_t'(PC_STEP);
    assign br_tgt = pc4 + (imm_sext << 2);
    assign j_tgt  = {pc4[31:28], Instr[25:0], 2'b00};

    // Jump outranks a taken branch
    always_comb begin
        pc_d = pc4;
        if (Jump) begin
            pc_d = j_tgt;
        end else if (Bzero) begin
            pc_d = br_tgt;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_imm_pc.sv
// Directed vector bench for imm_pc.
// Build with +define+IMM_ZEXT_EN to check the zero-extend variant.
module tb_imm_pc;

    logic        CLK;
    logic        reset;
    logic [31:0] Instr;
    logic        Jump;
    logic        Bzero;
    logic [31:0] imm;
    logic [31:0] PC;

    int errors = 0;
    int checks = 0;

    imm_pc #(.RESET_PC(32'h0000_0000)) dut (
        .CLK   (CLK),
        .reset (reset),
        .Instr (Instr),
        .Jump  (Jump),
        .Bzero (Bzero),
        .imm   (imm),
        .PC    (PC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        jmp;
        logic        bz;
        logic [31:0] exp_imm;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t v[22];

`ifdef IMM_ZEXT_EN
    localparam logic [31:0] IMM_ORI  = 32'h0000_8001;
    localparam logic [31:0] IMM_XORI = 32'h0000_8000;
`else
    localparam logic [31:0] IMM_ORI  = 32'hFFFF_8001;
    localparam logic [31:0] IMM_XORI = 32'hFFFF_8000;
`endif

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [31:0] ins,
                         input logic j, input logic b);
        @(negedge CLK);
        reset = r;
        Instr = ins;
        Jump  = j;
        Bzero = b;
    endtask

    initial begin
        // rst, instr, jump, bzero, imm, PC after edge
        for (int i = 0; i < 5; i++)
            v[i] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 32'h00005678, 32'h0};
        v[5]  = '{1'b0, 32'h12345678, 1'b0, 1'b0, 32'h00005678, 32'h4};
        v[6]  = '{1'b0, 32'h12345678, 1'b0, 1'b0, 32'h00005678, 32'h8};
        v[7]  = '{1'b0, 32'h12345678, 1'b0, 1'b0, 32'h00005678, 32'hC};
        v[8]  = '{1'b1, 32'h12345678, 1'b0, 1'b0, 32'h00005678, 32'h0};
        v[9]  = '{1'b0, 32'h12345678, 1'b1, 1'b0, 32'h00005678, 32'h08D159E0};
        v[10] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 32'h00005678, 32'h0};
        v[11] = '{1'b0, 32'h12345678, 1'b0, 1'b1, 32'h00005678, 32'h000159E4};
        v[12] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 32'h00005678, 32'h0};
        v[13] = '{1'b0, 32'h1234FFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0};
        v[14] = '{1'b0, 32'h12345678, 1'b1, 1'b1, 32'h00005678, 32'h08D159E0};
        v[15] = '{1'b1, 32'h12345678, 1'b1, 1'b1, 32'h00005678, 32'h0};
        v[16] = '{1'b0, 32'h34008001, 1'b0, 1'b1, IMM_ORI, 32'hFFFE0008};
        v[17] = '{1'b0, 32'h0BFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFC};
        v[18] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 32'h0};
        v[19] = '{1'b0, 32'h30007FFF, 1'b0, 1'b0, 32'h00007FFF, 32'h4};
        v[20] = '{1'b0, 32'h38008000, 1'b0, 1'b0, IMM_XORI, 32'h8};
        v[21] = '{1'b0, 32'h1000FFFE, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h4};

        reset = 1'b1;
        Instr = 32'h0;
        Jump  = 1'b0;
        Bzero = 1'b0;

        for (int i = 0; i < 22; i++) begin
            apply(v[i].rst, v[i].instr, v[i].jmp, v[i].bz);
            #1;
            check($sformatf("imm[%0d]", i), imm, v[i].exp_imm);
            @(posedge CLK);
            #1;
            check($sformatf("pc[%0d]", i), PC, v[i].exp_pc);
        end

        // controls must not move PC before the edge
        apply(1'b0, 32'h12345678, 1'b1, 1'b0);
        #1;
        check("pc_hold_before_edge", PC, 32'h4);
        @(posedge CLK);
        #1;
        check("pc_jump_from_4", PC, 32'h08D159E0);

        // reset held several cycles mid-run keeps PC at RESET_PC
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 32'h1000FFFE, 1'b0, 1'b1);
            @(posedge CLK);
            #1;
            check($sformatf("pc_rst_hold[%0d]", k), PC, 32'h0);
        end

        // sequential run then branch backwards
        apply(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        check("pc_seq_4", PC, 32'h4);
        apply(1'b0, 32'h1000FFFF, 1'b0, 1'b1);
        @(posedge CLK);
        #1;
        check("pc_branch_self", PC, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
